// File: rtl/mult_sequencer.sv
// ============================================================================
// Module      : mult_sequencer
// Description : Queues 4-bit operand pairs and runs them one at a time through
//               an external 4x4 multiplier using a clear/start/wait/capture
//               sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mult_sequencer #(
  parameter int WAIT_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] mul_in1,
  output logic [3:0] mul_in2,
  output logic       mul_start,
  output logic       mul_rst,
  input  logic [7:0] mul_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_product
);

  localparam logic [5:0] c_wait_load = 6'(WAIT_CYCLES - 1);
  localparam logic [2:0] c_fifo_full = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       r_in_ready;
  logic [3:0] r_op_a;
  logic [3:0] r_op_b;
  logic [5:0] r_wait_cnt;
  logic [7:0] r_out_product;
  logic       r_mul_rst;
  logic       r_mul_start;
  logic       r_out_valid;

  logic       w_push;
  logic       w_pop;
  logic [2:0] w_count_nxt;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = (r_state == S_IDLE) && (r_count != 3'd0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 3'd1;
      2'b01:   w_count_nxt = r_count - 3'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b};
    end
  end

  // in_ready is held low through reset and follows the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= 2'd0;
      r_rd_ptr   <= 2'd0;
      r_count    <= 3'd0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != c_fifo_full);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op_a        <= 4'd0;
      r_op_b        <= 4'd0;
      r_wait_cnt    <= 6'd0;
      r_out_product <= 8'd0;
      r_mul_rst     <= 1'b0;
      r_mul_start   <= 1'b0;
      r_out_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_op_a    <= r_mem[r_rd_ptr][7:4];
            r_op_b    <= r_mem[r_rd_ptr][3:0];
            r_mul_rst <= 1'b1;
            r_state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_mul_rst   <= 1'b0;
          r_mul_start <= 1'b1;
          r_state     <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_mul_start <= 1'b0;
          r_wait_cnt  <= c_wait_load;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == 6'd0) begin
            r_out_product <= mul_result;
            r_out_valid   <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 6'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_mul_rst   <= 1'b0;
          r_mul_start <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // The multiplier is cleared together with the sequencer, without waiting for a clock.
  assign mul_rst     = r_mul_rst | rst;
  assign mul_start   = r_mul_start;
  assign mul_in1     = r_op_a;
  assign mul_in2     = r_op_b;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_product = r_out_product;

endmodule

`default_nettype wire

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter WAIT_CYCLES, default 10, SHALL set the number of clk cycles the block waits after the start pulse before capturing the product (legal range 2..63).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  operand FIFO can accept a pair.
REQ-006 in_a  input  4  unsigned operand A.
REQ-007 in_b  input  4  unsigned operand B.
REQ-008 mul_in1  output  4  operand A driven to the downstream 4x4 multiplier.
REQ-009 mul_in2  output  4  operand B driven to the multiplier.
REQ-010 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-011 mul_rst  output  1  clear pulse to the multiplier.
REQ-012 mul_result  input  8  product returned by the multiplier.
REQ-013 out_valid  output  1  captured product available.
REQ-014 out_ready  input  1  consumer accepts the product.
REQ-015 out_product  output  8  captured product.

Function
REQ-016 The block SHALL contain a 4-entry FIFO of 8-bit {in_a,in_b} pairs with a 3-bit occupancy count (0..4) and 2-bit wrapping read/write pointers.
REQ-017 in_ready SHALL be 1 exactly when the count < 4, derived from registered state only.
REQ-018 A push SHALL occur on an edge with in_valid=1 and in_ready=1; in_valid while full SHALL be ignored, with no overwrite.
REQ-019 When a push and a pop occur on the same edge, the count SHALL be unchanged and both pointers SHALL advance.
REQ-020 The FSM SHALL have the states IDLE, CLEAR, LAUNCH, WAIT and DONE.
REQ-021 IDLE: if the count > 0, the block SHALL pop the head into registers op_a/op_b and go to CLEAR; otherwise it SHALL stay in IDLE.
REQ-022 CLEAR: mul_rst=1 for exactly one cycle, then the FSM SHALL go to LAUNCH.
REQ-023 LAUNCH: mul_start=1 for exactly one cycle, a wait counter SHALL load WAIT_CYCLES-1, and the FSM SHALL go to WAIT.
REQ-024 WAIT: the counter SHALL decrement each cycle; on the edge where it is 0, mul_result SHALL be latched into out_product and the FSM SHALL go to DONE.
REQ-025 DONE: out_valid=1; on an edge with out_ready=1 the FSM SHALL go to IDLE; out_valid and out_product SHALL stay stable while out_ready=0.
REQ-026 mul_in1/mul_in2 SHALL equal op_a/op_b and stay constant from CLEAR through the end of DONE.
REQ-027 mul_start, mul_rst and out_valid SHALL be registered state decodes with no glitches, and SHALL be 0 in every state other than the one named.
REQ-028 Latency: out_valid SHALL rise WAIT_CYCLES+2 cycles after the pop edge (12 cycles at the default).
REQ-029 A new operation SHALL NOT start before the DONE handshake completes, so no more than one operation is ever in flight.
REQ-030 Pushes SHALL continue to be accepted in every FSM state, limited only by the count.
REQ-031 out_product SHALL be the unmodified 8-bit mul_result value; the block SHALL perform no arithmetic on it.

Reset
REQ-032 Asserting rst SHALL immediately force the FSM to IDLE, empty the FIFO (count=0, pointers=0), and clear op_a, op_b, out_product and the wait counter to 0.
REQ-033 During reset: in_ready=0, out_valid=0, mul_start=0.
REQ-034 mul_rst SHALL be 1 combinationally while rst=1, so the multiplier is cleared with the sequencer.
REQ-035 Reset asserted mid-operation (any state) SHALL discard the operation and all queued pairs, and produce no out_valid afterwards until a new push.
REQ-036 After rst deasserts, in_ready SHALL be 1 from the first edge onward.

Verification
REQ-037 Push 15,15 into an idle block with out_ready=1 -> one-cycle mul_rst, then one-cycle mul_start, then out_valid 12 cycles after the pop with out_product=225.
REQ-038 Push 0,7 -> out_product=0; push 1,9 -> out_product=9; push 15,1 -> out_product=15; results delivered in push order.
REQ-039 Push 5 pairs back-to-back with out_ready=1 -> in_ready drops to 0 when the count reaches 4; the 5th pair is accepted after the first pop; all 5 products are correct and in order.
REQ-040 Hold out_ready=0 for 20 cycles in DONE -> out_valid and out_product stay stable, no new mul_start occurs, and pushes still fill the FIFO up to 4.
REQ-041 Assert rst during WAIT with 2 pairs queued -> out_valid=0, count=0 and mul_rst=1 immediately; after release, no output appears until a new push.
REQ-042 Exhaustive run of all 256 in_a x in_b pairs against a behavioural multiplier model -> every out_product equals in_a*in_b, and the mismatch count is 0.
